// File: rtl/adder_pkg.sv
// adder_pkg: shared width default and flag-register layout for alu_adder.
//   ADDER_WIDTH_DEFAULT : default operand width
//   flags_t             : packed {ovf, zero, neg} status flags
package adder_pkg;
    localparam int ADDER_WIDTH_DEFAULT = 4;
    typedef struct packed {
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell of the ripple chain.
//   a, b : operand bits    ci : carry in
//   s    : sum bit         co : carry out (majority of a, b, ci)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/alu_adder.sv
// alu_adder: registered WIDTH-bit ripple-carry adder, {cout, y} = a + b + cin, 1-cycle latency.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid, a, b, cin : operands, captured when in_valid = 1
//   out_valid       : y/cout (and flags) hold a fresh result this cycle
//   y, cout         : registered sum and carry-out of the MSB
//   ovf, zero, neg  : registered signed status flags, present only when ADDER_FLAGS_EN is defined
module alu_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             cout
`ifdef ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero,
    output logic             neg
`endif
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y    <= s;
                cout <= c[WIDTH];
            end
        end
    end

`ifdef ADDER_FLAGS_EN
    flags_t flags_d, flags_q;

    // Flags come from the sum being captured, not from the current y.
    // For WIDTH = 1, c[WIDTH-1] is cin, giving ovf = cout ^ cin.
    always_comb begin
        flags_d.ovf  = c[WIDTH] ^ c[WIDTH-1];
        flags_d.zero = (s == '0);
        flags_d.neg  = s[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= '0;
        else if (in_valid) flags_q <= flags_d;
    end

    assign ovf  = flags_q.ovf;
    assign zero = flags_q.zero;
    assign neg  = flags_q.neg;
`endif
endmodule

// File: tb/tb_alu_adder.sv
// tb_alu_adder: directed self-checking bench for alu_adder at WIDTH = 4 and WIDTH = 32.
module tb_alu_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic [3:0]  y;
    logic        cout;
    logic        iv32 = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic        cin32 = 1'b0;
    logic        ov32;
    logic [31:0] y32;
    logic        cout32;
`ifdef ADDER_FLAGS_EN
    logic        ovf, zero, neg;
    logic        ovf32, zero32, neg32;
`endif

    int pass_cnt = 0;
    int total = 0;

    logic [3:0] va, vb, ey;
    logic       vc, eco, eov, ez, en;
    logic [16:0] t [4];

    always #5 clk = ~clk;

    alu_adder #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .y(y), .cout(cout)
`ifdef ADDER_FLAGS_EN
        , .ovf(ovf), .zero(zero), .neg(neg)
`endif
    );

    alu_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .a(a32), .b(b32), .cin(cin32),
        .out_valid(ov32), .y(y32), .cout(cout32)
`ifdef ADDER_FLAGS_EN
        , .ovf(ovf32), .zero(zero32), .neg(neg32)
`endif
    );

    task automatic drive(input logic [3:0] da, input logic [3:0] db, input logic dc, input logic dv);
        @(negedge clk);
        a = da;
        b = db;
        cin = dc;
        in_valid = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            {va, vb, vc, ey, eco, eov, ez, en} = t[i];
            drive(va, vb, vc, 1'b1);
            total++;
            if ({out_valid, cout, y} !== {1'b1, eco, ey})
                $display("FAIL %s[%0d] sum: got v=%b c=%b y=%b, want v=1 c=%b y=%b", name, i, out_valid, cout, y, eco, ey);
            else pass_cnt++;
`ifdef ADDER_FLAGS_EN
            total++;
            if ({ovf, zero, neg} !== {eov, ez, en})
                $display("FAIL %s[%0d] flags: got ovf/zero/neg=%b%b%b, want %b%b%b", name, i, ovf, zero, neg, eov, ez, en);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(4'b0101, 4'b0000, 1'b0, 1'b1);
            total++;
            if ({out_valid, cout, y} !== 6'b0)
                $display("FAIL reset[%0d]: got v=%b c=%b y=%b, want all 0", i, out_valid, cout, y);
            else pass_cnt++;
`ifdef ADDER_FLAGS_EN
            total++;
            if ({ovf, zero, neg} !== 3'b0)
                $display("FAIL reset_flags[%0d]: got %b%b%b, want 000", i, ovf, zero, neg);
            else pass_cnt++;
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, cout, y} !== {1'b1, 1'b0, 4'b0101})
            $display("FAIL reset_release: got v=%b c=%b y=%b, want v=1 c=0 y=0101", out_valid, cout, y);
        else pass_cnt++;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_identity();
        t[0] = {4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        t[1] = {4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
        t[2] = {4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
        t[3] = {4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
        run_table(4, "identity");
    endtask

    task automatic test_plain_add();
        t[0] = {4'b0101, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
        t[1] = {4'b0100, 4'b0110, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1};
        run_table(2, "plain_add");
    endtask

    task automatic test_carry_wrap();
        t[0] = {4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};
        t[1] = {4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};
        t[2] = {4'b0111, 4'b1001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
        t[3] = {4'b1001, 4'b1010, 1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0};
        run_table(4, "carry_wrap");
    endtask

    task automatic test_hold();
        drive(4'b0101, 4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 4'b1111, 1'b1, 1'b0);
            total++;
            if ({out_valid, cout, y} !== {1'b0, 1'b0, 4'b0110})
                $display("FAIL hold[%0d]: got v=%b c=%b y=%b, want v=0 c=0 y=0110", i, out_valid, cout, y);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            va = 4'(3 * i + 2);
            vb = 4'(5 * i + 7);
            vc = 1'(i);
            drive(va, vb, vc, 1'b1);
            total++;
            if ({out_valid, cout, y} !== {1'b1, 5'({1'b0, va} + {1'b0, vb} + 5'(vc))})
                $display("FAIL back_to_back[%0d]: got v=%b c=%b y=%b for %h+%h+%b", i, out_valid, cout, y, va, vb, vc);
            else pass_cnt++;
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_exhaustive();
        logic [4:0] sum;
        int bad = 0;
        for (int i = 0; i < 512; i++) begin
            {va, vb, vc} = 9'(i);
            sum = {1'b0, va} + {1'b0, vb} + 5'(vc);
            drive(va, vb, vc, 1'b1);
            total++;
            if ({out_valid, cout, y} !== {1'b1, sum}) begin
                if (bad < 8) $display("FAIL exhaustive %h+%h+%b: got v=%b c=%b y=%b, want c=%b y=%b", va, vb, vc, out_valid, cout, y, sum[4], sum[3:0]);
                bad++;
            end else pass_cnt++;
`ifdef ADDER_FLAGS_EN
            total++;
            if ({ovf, zero, neg} !== {(va[3] == vb[3]) && (sum[3] != va[3]), sum[3:0] == 4'b0, sum[3]}) begin
                if (bad < 8) $display("FAIL exhaustive_flags %h+%h+%b: got %b%b%b", va, vb, vc, ovf, zero, neg);
                bad++;
            end else pass_cnt++;
`endif
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_random32();
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] sum;
        int bad = 0;
        for (int i = 0; i < 200; i++) begin
            ra = (i < 2) ? 32'hFFFF_FFFF : $urandom;
            rb = (i == 0) ? 32'h1 : (i == 1) ? 32'h8000_0000 : $urandom;
            rc = (i < 2) ? 1'b0 : 1'($urandom);
            sum = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            @(negedge clk);
            a32 = ra;
            b32 = rb;
            cin32 = rc;
            iv32 = 1'b1;
            @(posedge clk);
            #1;
            total++;
            if ({ov32, cout32, y32} !== {1'b1, sum}) begin
                if (bad < 8) $display("FAIL random32 %h+%h+%b: got v=%b c=%b y=%h, want c=%b y=%h", ra, rb, rc, ov32, cout32, y32, sum[32], sum[31:0]);
                bad++;
            end else pass_cnt++;
`ifdef ADDER_FLAGS_EN
            total++;
            if ({ovf32, zero32, neg32} !== {(ra[31] == rb[31]) && (sum[31] != ra[31]), sum[31:0] == 32'b0, sum[31]}) begin
                if (bad < 8) $display("FAIL random32_flags %h+%h+%b: got %b%b%b", ra, rb, rc, ovf32, zero32, neg32);
                bad++;
            end else pass_cnt++;
`endif
        end
        @(negedge clk);
        iv32 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ov32 !== 1'b0)
            $display("FAIL random32_idle: got out_valid=%b, want 0", ov32);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_plain_add();
        test_carry_wrap();
        test_hold();
        test_back_to_back();
        test_exhaustive();
        test_random32();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
